// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared state encoding and default sizing for the P2 non-restoring divider.
package div_seq_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, STEP, WAIT, FIX, DONE} state_e;
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_TIMEOUT = 4;
endpackage

// File: rtl/div_seq_timer.sv
// div_seq_timer: counts WAIT cycles and flags expiry on the last allowed cycle.
module div_seq_timer
    import div_seq_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + TW'(1);
    end
    assign expire_o = en_i && cnt_q == TW'(TIMEOUT - 1);
endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: Moore sequencer driving load, per-iteration step enables and the
// optional remainder restore of the non-restoring divider.
module div_seq_ctrl
    import div_seq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CNT_W   = $clog2(WIDTH + 1),
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             rem_neg,
    input  logic             step_flag,
    output logic             load,
    output logic             step_en,
    output logic             sub_op,
    output logic             fix_en,
    output logic [CNT_W-1:0] iter,
    output logic             busy,
    output logic             done,
    output logic             err
);
    state_e state_q;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic sub_op_q, err_q, expire, last;
    // flag has priority over expiry, so a flag on the final allowed cycle is accepted
    div_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (state_q != WAIT || step_flag),
        .en_i    (state_q == WAIT),
        .expire_o(expire)
    );
    assign iter_d = iter_q == CNT_W'(WIDTH) ? iter_q : iter_q + CNT_W'(1);
    assign last   = iter_q == CNT_W'(WIDTH - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            iter_q   <= '0;
            sub_op_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (abort && state_q != IDLE) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) state_q <= LOAD;
                LOAD: begin
                    state_q  <= STEP;
                    iter_q   <= '0;
                    sub_op_q <= 1'b1;
                    err_q    <= 1'b0;
                end
                STEP: state_q <= WAIT;
                WAIT: begin
                    if (step_flag) begin
                        iter_q   <= iter_d;
                        sub_op_q <= ~rem_neg;
                        state_q  <= last ? (rem_neg ? FIX : DONE) : STEP;
                    end else if (expire) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                FIX:     state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign load    = state_q == LOAD;
    assign step_en = state_q == STEP;
    assign fix_en  = state_q == FIX;
    assign done    = state_q == DONE;
    assign busy    = state_q != IDLE;
    assign iter    = iter_q;
    assign sub_op  = sub_op_q;
    assign err     = err_q;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed runs of the division sequencer with an ideal select-stage responder.
module tb_div_seq_ctrl;
    logic clk, rst, start, abort, rem_neg, step_flag;
    logic load, step_en, sub_op, fix_en, busy, done, err;
    logic [4:0] iter;
    int n_chk, n_err;
    int cyc, n_step, n_done, n_fix, c_done, c_fix, c_err;
    logic [15:0] subs;
    logic [63:0] busy_hist, err_hist;

    div_seq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .rem_neg  (rem_neg),
        .step_flag(step_flag),
        .load     (load),
        .step_en  (step_en),
        .sub_op   (sub_op),
        .fix_en   (fix_en),
        .iter     (iter),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Select stage model: step_flag answers on the cycle after step_en, carrying rn[k] as the sign.
    task automatic run(input logic [15:0] rn, input bit use_flag, input int abort_iter,
                       input int rst_iter, input bit start_in_done, input int ncyc);
        logic pend, fprev, aborted, rsted;
        int nf;
        pend = 0; fprev = 0; aborted = 0; rsted = 0; nf = 0;
        n_step = 0; n_done = 0; n_fix = 0; c_done = -1; c_fix = -1; c_err = -1;
        subs = '0; busy_hist = '0; err_hist = '0;
        cyc = 0;
        start = 1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            cyc++;
            start = 0; abort = 0; rst = 1;
            if (fprev) subs[nf-1] = sub_op;
            busy_hist[cyc] = busy;
            err_hist[cyc]  = err;
            if (step_en) n_step++;
            if (fix_en) begin n_fix++; c_fix = cyc; end
            if (done) begin n_done++; c_done = cyc; start = start_in_done; end
            if (err && c_err < 0) c_err = cyc;
            step_flag = use_flag && pend;
            fprev = step_flag;
            if (step_flag) begin rem_neg = rn[nf[3:0]]; nf++; end
            else rem_neg = 1'b1;
            pend = step_en;
            if (busy && !aborted && iter == abort_iter) begin abort = 1; aborted = 1; end
            if (busy && !rsted && iter == rst_iter) begin
                rst = 0; rsted = 1;
                #1 chk("reset_async", {load, step_en, sub_op, fix_en, iter, busy, done, err}, 0);
            end
        end
        step_flag = 0;
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        clk = 0; rst = 0; start = 0; abort = 0; rem_neg = 0; step_flag = 0;
        #1 chk("reset_outputs", {load, step_en, sub_op, fix_en, iter, busy, done, err}, 0);
        @(negedge clk); rst = 1;
        @(negedge clk);

        run(16'h0000, 1, -1, -1, 0, 40);
        chk("a_steps", n_step, 16);
        chk("a_done_cyc", c_done, 34);
        chk("a_done_cnt", n_done, 1);
        chk("a_no_fix", n_fix, 0);
        chk("a_iter", iter, 16);
        chk("a_sub_op", subs, 16'hFFFF);
        chk("a_busy_at_done", busy_hist[34], 1);
        chk("a_busy_after", busy_hist[35], 0);

        run(16'h8000, 1, -1, -1, 0, 40);
        chk("b_fix_cyc", c_fix, 34);
        chk("b_done_cyc", c_done, 35);
        chk("b_sub_op", subs, 16'h7FFF);
        chk("b_iter", iter, 16);

        run(16'h0006, 1, -1, -1, 0, 40);
        chk("c_sub_op", subs, 16'hFFF9);
        chk("c_done_cyc", c_done, 34);
        chk("c_no_fix", n_fix, 0);

        run(16'h0000, 0, -1, -1, 0, 12);
        chk("d_err_cyc", c_err, 7);
        chk("d_done_cyc", c_done, 7);
        chk("d_done_cnt", n_done, 1);
        chk("d_iter", iter, 0);
        chk("d_steps", n_step, 1);
        chk("d_err_sticky", err, 1);

        run(16'h0000, 1, -1, -1, 0, 40);
        chk("e_err_in_load", err_hist[1], 1);
        chk("e_err_cleared", err_hist[2], 0);
        chk("e_done_cyc", c_done, 34);

        run(16'h0000, 1, 5, -1, 0, 40);
        chk("f_no_done", n_done, 0);
        chk("f_iter_held", iter, 5);
        chk("f_busy_before", busy_hist[12], 1);
        chk("f_busy_after", busy_hist[13], 0);

        run(16'h0000, 1, -1, -1, 1, 42);
        chk("g_done_cyc", c_done, 34);
        chk("g_done_cnt", n_done, 1);
        chk("g_start_ignored", busy_hist[42:35], 0);

        run(16'h0000, 1, -1, 8, 0, 30);
        chk("h_no_done", n_done, 0);
        chk("h_idle", busy, 0);

        run(16'h0000, 1, -1, -1, 0, 40);
        chk("i_done_cyc", c_done, 34);
        chk("i_steps", n_step, 16);
        chk("i_iter", iter, 16);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Iterative-division sequencer for the P2 non-restoring divider datapath. It accepts a start request and pulses load for the operand registers. It then drives one enable per iteration into the remainder-sign select stage, using that stage's completion flag and the remainder sign to choose add or subtract for the next iteration. It finishes with an optional restore step and a one-cycle done pulse.

## Interface
- WIDTH, 16: quotient width, which is also the iteration count.
- CNT_W, $clog2(WIDTH+1): iteration counter width.
- TIMEOUT, 4: maximum WAIT cycles allowed for step_flag before an error is raised.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request a division; sampled only in IDLE.
- abort  in  1  synchronous cancel; effective in any state except IDLE.
- rem_neg  in  1  sign bit of the datapath remainder R (1 = R < 0).
- step_flag  in  1  completion flag from the select stage; high for one cycle after it samples step_en.
- load  out  1  load dividend/divisor into the datapath registers.
- step_en  out  1  Enable for the select stage, one cycle per iteration.
- sub_op  out  1  operation for the next iteration: 1 = subtract, 0 = add.
- fix_en  out  1  final remainder restore (R + divisor).
- iter  out  CNT_W  number of completed iterations.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky; step_flag timed out.

## Operation
- Moore FSM with states IDLE, LOAD, STEP, WAIT, FIX, DONE. All outputs decode from the state register plus the registered iter, sub_op and err.
- IDLE: all strobes low.
  - start=1 → LOAD.
- LOAD: load=1.
  - Set iter←0, sub_op←1, err←0, wait counter←0.
  - Next state STEP.
- STEP: step_en=1.
  - Next state WAIT.
- WAIT: strobes low; wait counter increments each cycle.
  - On step_flag=1: iter←iter+1; sub_op←~rem_neg; wait counter←0.
  - If iter+1==WIDTH: go to FIX if rem_neg=1, otherwise DONE.
  - Otherwise go to STEP.
  - If step_flag=0 and the wait counter reaches TIMEOUT-1: err←1, go to DONE.
- FIX: fix_en=1.
  - Next state DONE.
- DONE: done=1.
  - Next state IDLE.
- abort=1 in any state except IDLE → IDLE on the next edge. done is not pulsed, and iter holds its value.
  - abort has priority over every other transition.
  - abort in LOAD counts as an abort, so err is not cleared by that LOAD.
- start outside IDLE is ignored, including start in DONE. A new request needs IDLE first.
- rem_neg and step_flag are ignored outside WAIT.
- iter saturates at WIDTH, holds its value in IDLE, and is reloaded only in LOAD.
- err stays set until the next LOAD or reset.

## Timing
- Reset values: all outputs 0, state IDLE, iter=0, sub_op=0, err=0. Reset mid-operation abandons the division immediately with no done pulse.
- Let edge e0 be the edge that samples start in IDLE.
  - Cycle 1: LOAD.
  - Then each iteration takes 2 cycles (STEP, WAIT) when step_flag returns on the first WAIT cycle.
- Start-to-done latency for WIDTH=16: done is high in cycle 34 without FIX, or cycle 35 with FIX. busy falls the cycle after done.
- Back-to-back operation: the earliest next LOAD is 2 cycles after done (DONE → IDLE → LOAD).
- A late step_flag stretches WAIT by one cycle per cycle of delay, up to TIMEOUT cycles total.

## Structure
- Package div_seq_pkg holds the state enum type (IDLE..DONE) and the default WIDTH and TIMEOUT localparams. The datapath uses the same package.
- Sub-module div_seq_timer: WAIT-cycle counter with clear and expire outputs, parameterised by TIMEOUT.
- Everything else lives in div_seq_ctrl.

## Test plan
- Normal run, no restore: WIDTH=16, step_flag returned one cycle after each step_en, rem_neg=0 throughout → 16 step_en pulses, sub_op=1 throughout, fix_en never high, done in cycle 34, iter=16.
- Restore run: rem_neg=1 on the 16th step_flag → fix_en high in cycle 34, done in cycle 35.
- Alternating signs: rem_neg pattern 0,1,1,0 on iterations 1–4 → sub_op after each iteration is 1,0,0,1.
- Timeout: step_flag never asserted after the first step_en → err=1 after 4 WAIT cycles, then done high for one cycle, iter=0. The next start clears err in LOAD.
- Abort, then ignored start: abort while iter=5 → IDLE next cycle, no done, iter=5. A start during DONE of a later run is ignored, and busy stays 0 after that run finishes.
- Reset mid-run: rst low at iter=8 → all outputs 0 asynchronously. After release, start produces a full 34-cycle run.
